wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter for the 16-bit, 8-register CPU. It takes write requests from several producers (ALU, load unit, immediate move) and grants one per cycle using round-robin priority. The winner is driven onto the single register-file write port through a registered output stage. The block sits between the execute/memory stages and the write-back register file, and is the only driver of that file's write port.

## Interface
Parameters:
- DW, 16, data width of one register write
- RW, 3, register index width (2**RW registers)
- N_REQ, 3, number of requesters (IDs 0..N_REQ-1)

Ports:
- clk_wb  in  1  write-back clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  bit i: requester i has a write pending
- req_ready  out  N_REQ  bit i: requester i accepted this cycle (combinational)
- req_dst  in  N_REQ*RW  requester i destination at [i*RW +: RW]
- req_data  in  N_REQ*DW  requester i data at [i*DW +: DW]
- wb_stall  in  1  pipeline hold; no grants while high
- wb_we  out  1  register-file write enable, registered
- n_reg  out  RW  register-file write index, registered
- reg_in  out  DW  register-file write data, registered
- wb_src  out  2  ID of the requester now on the write port, registered
- busy  out  2**RW  one-hot of n_reg when wb_we=1, else 0 (decoded from registers)

## Operation
- Single clock, clk_wb. Reset is asynchronous and active-low.
- Reset value of every output and state element is 0: wb_we, n_reg, reg_in, wb_src, busy, and the round-robin pointer ptr.
- Arbitration (combinational):
  - When wb_stall=0, scan req_valid starting at index ptr and wrap modulo N_REQ.
  - The first valid index g is granted: req_ready is one-hot at g.
  - When wb_stall=1, or no request is valid, req_ready is 0.
- A transfer occurs when req_valid[g] and req_ready[g] are both 1.
- On a transfer, at the next edge: wb_we<=1, n_reg<=req_dst[g], reg_in<=req_data[g], wb_src<=g, ptr<=(g+1) mod N_REQ.
- With no transfer, at the next edge: wb_we<=0, and n_reg, reg_in, wb_src and ptr hold.
- Requester rule: once req_valid is raised, it must stay high with dst and data stable until ready. Dropping valid early is a protocol violation; the arbiter does not check for it.
- Register file rule: it writes only when wb_we=1. The arbiter never drives wb_we=1 with a stale index.
- Two requesters targeting the same register in one cycle: each is written in grant order. The later grant's data is the final value. Neither write is merged or dropped.
- Reset asserted mid-operation: outputs clear immediately, with no edge needed. An accepted but not yet written request is lost. Requesters must re-present after reset.

## Timing
- Accept latency is 0 cycles: req_ready is asserted in the same cycle as req_valid if the request wins.
- Write latency is 1 cycle: wb_we/n_reg/reg_in are valid in the cycle after acceptance.
- Throughput is one write per cycle. No bubble is required between back-to-back grants.
- Fairness bound: a continuously valid requester is granted within N_REQ non-stalled cycles.
- wb_stall takes effect in the same cycle it is asserted. ptr is frozen throughout the stall.
- After reset deassertion, the first grant can occur in the first cycle. Priority starts at requester 0.

## Structure
- Package wb_pkg holds:
  - DW, RW and N_REQ defaults
  - requester IDs: REQ_ALU=0, REQ_LOAD=1, REQ_IMM=2
  - the wb_src width constant
- One sub-module, wb_rr_pick: a combinational round-robin picker.
  - Inputs: valid vector, ptr, enable.
  - Outputs: one-hot grant and encoded index g.
- The top level holds ptr, the output register stage and the busy decode.

## Test plan
- Reset: pull reset low while wb_we=1, n_reg=6 -> wb_we=0, n_reg=0, reg_in=0, busy=0 before the next edge; after release, the first grant goes to requester 0 if valid.
- Single write: requester 1 valid, dst=5, data=16'hBEEF -> req_ready=3'b010 that cycle; next cycle wb_we=1, n_reg=5, reg_in=16'hBEEF, wb_src=1, busy=8'b0010_0000.
- Rotation: all three valid continuously from ptr=0 -> grant sequence 0,1,2,0,1 on consecutive cycles, with wb_we=1 every cycle.
- Stall: all valid, wb_stall=1 for 2 cycles after granting 0 -> req_ready=0 and wb_we=0 for 2 cycles; the first grant after release is 1.
- Same destination: req0 dst=3 data=16'h1111 and req2 dst=3 data=16'h2222, ptr=0 -> the write port shows 3/1111, then 3/2222 on consecutive cycles.
- Idle hold: no valid after writing 2/16'hA5A5 -> wb_we=0 and busy=0, with n_reg=2 and reg_in=16'hA5A5 held, and ptr unchanged.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter.
// Holds the default bus geometry, the fixed requester IDs and the width
// of the source-ID field that tells the register file who is writing.
package wb_pkg;

    localparam int DW    = 16;  // data width of one register write
    localparam int RW    = 3;   // register index width (2**RW registers)
    localparam int N_REQ = 3;   // number of write-back requesters

    // Width of wb_src and of the round-robin pointer.
    localparam int SRC_W = 2;

    typedef enum logic [SRC_W-1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_IMM  = 2'd2
    } req_id_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the write-back producers and the arbiter.
//   master : producer side, drives requests and the stall, observes the port
//   slave  : arbiter side, accepts requests and drives the register-file port
// Requester i uses req_dst[i*RW +: RW] and req_data[i*DW +: DW].
interface wb_arbiter_if #(
    parameter int DW    = wb_pkg::DW,
    parameter int RW    = wb_pkg::RW,
    parameter int N_REQ = wb_pkg::N_REQ
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*RW-1:0]     req_dst;
    logic [N_REQ*DW-1:0]     req_data;
    logic                    wb_stall;
    logic                    wb_we;
    logic [RW-1:0]           n_reg;
    logic [DW-1:0]           reg_in;
    logic [wb_pkg::SRC_W-1:0] wb_src;
    logic [(2**RW)-1:0]      busy;

    modport master (
        output req_valid, req_dst, req_data, wb_stall,
        input  req_ready, wb_we, n_reg, reg_in, wb_src, busy
    );

    modport slave (
        input  req_valid, req_dst, req_data, wb_stall,
        output req_ready, wb_we, n_reg, reg_in, wb_src, busy
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   valid  : request vector
//   ptr    : index with highest priority this cycle (must be < N)
//   enable : when low, nothing is granted
//   grant  : one-hot grant (all zero when nothing granted)
//   g      : encoded index of the granted requester (0 when nothing granted)
module wb_rr_pick
    import wb_pkg::*;
#(
    parameter int N  = wb_pkg::N_REQ,
    parameter int IW = wb_pkg::SRC_W
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] g
);

    // Walk the offsets from farthest to nearest so the requester closest to
    // ptr (in wrap-around order) overwrites any earlier hit and wins.
    always_comb begin
        int             idx;
        logic [IW-1:0]  idx_sel;
        grant   = '0;
        g       = '0;
        idx     = 0;
        idx_sel = '0;
        if (enable) begin
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                idx_sel = IW'(idx);
                if (valid[idx_sel]) begin
                    grant          = '0;
                    grant[idx_sel] = 1'b1;
                    g              = idx_sel;
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: picks one producer per cycle (round-robin) and drives
// the single register-file write port through a registered stage.
// Ports:
//   clk_wb : write-back clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : slave side of wb_arbiter_if (requests in, ready and the
//            registered write port wb_we/n_reg/reg_in/wb_src out, plus busy)
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DW    = wb_pkg::DW,
    parameter int RW    = wb_pkg::RW,
    parameter int N_REQ = wb_pkg::N_REQ
) (
    input  logic        clk_wb,
    input  logic        reset,
    wb_arbiter_if.slave bus
);

    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   g;
    logic [N_REQ-1:0]   grant;
    logic               xfer;

    logic               wb_we_q;
    logic [RW-1:0]      n_reg_q;
    logic [DW-1:0]      reg_in_q;
    logic [SRC_W-1:0]   wb_src_q;
    logic [(2**RW)-1:0] busy_d;

    // A stall blocks granting in the same cycle, which also freezes ptr
    // because no transfer can happen.
    wb_rr_pick #(
        .N  (N_REQ),
        .IW (SRC_W)
    ) u_pick (
        .valid  (bus.req_valid),
        .ptr    (ptr),
        .enable (!bus.wb_stall),
        .grant  (grant),
        .g      (g)
    );

    assign bus.req_ready = grant;
    assign xfer          = |(bus.req_valid & grant);

    // Output stage and pointer. Without a transfer only wb_we drops; the
    // index and data hold so the port never shows a stale write enable.
    always_ff @(posedge clk_wb or negedge reset) begin
        if (!reset) begin
            wb_we_q  <= 1'b0;
            n_reg_q  <= '0;
            reg_in_q <= '0;
            wb_src_q <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            wb_we_q  <= 1'b1;
            n_reg_q  <= bus.req_dst[g*RW +: RW];
            reg_in_q <= bus.req_data[g*DW +: DW];
            wb_src_q <= g;
            ptr      <= (int'(g) == N_REQ - 1) ? '0 : g + SRC_W'(1);
        end else begin
            wb_we_q  <= 1'b0;
        end
    end

    // busy is decoded from the registered port so it clears with reset
    // without needing an edge.
    always_comb begin
        busy_d = '0;
        if (wb_we_q) begin
            busy_d[n_reg_q] = 1'b1;
        end
    end

    assign bus.wb_we  = wb_we_q;
    assign bus.n_reg  = n_reg_q;
    assign bus.reg_in = reg_in_q;
    assign bus.wb_src = wb_src_q;
    assign bus.busy   = busy_d;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: reset, single write, rotation, stall,
// same-destination ordering and idle hold, with hand-computed expectations.
module tb_wb_arbiter;
    import wb_pkg::*;

    logic clk_wb;
    logic reset;
    int   tests_run;
    int   tests_failed;

    wb_arbiter_if #(.DW(16), .RW(3), .N_REQ(3)) bus ();

    wb_arbiter #(.DW(16), .RW(3), .N_REQ(3)) dut (
        .clk_wb (clk_wb),
        .reset  (reset),
        .bus    (bus)
    );

    // Free-running write-back clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_wb = 1'b0;
        forever #5 clk_wb = ~clk_wb;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives all producer-side inputs at once.
    task automatic applyStimulus(input logic [2:0] valid,
                                 input logic [2:0] d0, input logic [2:0] d1,
                                 input logic [2:0] d2,
                                 input logic [15:0] x0, input logic [15:0] x1,
                                 input logic [15:0] x2, input logic stall);
        bus.req_valid = valid;
        bus.req_dst   = {d2, d1, d0};
        bus.req_data  = {x2, x1, x0};
        bus.wb_stall  = stall;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk_wb);
        #1;
    endtask

    // Checks the registered write port after an edge.
    task automatic checkPort(input string tag, input logic we,
                             input logic [2:0] nreg, input logic [15:0] data,
                             input logic [1:0] src, input logic [7:0] busy);
        checkOutput({tag, "_we"},   32'(bus.wb_we),  32'(we));
        checkOutput({tag, "_nreg"}, 32'(bus.n_reg),  32'(nreg));
        checkOutput({tag, "_data"}, 32'(bus.reg_in), 32'(data));
        checkOutput({tag, "_src"},  32'(bus.wb_src), 32'(src));
        checkOutput({tag, "_busy"}, 32'(bus.busy),   32'(busy));
    endtask

    // Rotation data: requester i writes register i+1 with a distinct value.
    localparam logic [15:0] ROT_DATA [3] = '{16'h000A, 16'h001B, 16'h002C};

    initial begin
        logic [1:0] rot_seq [7];
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);

        // Reset state.
        #3;
        checkPort("reset_init", 1'b0, 3'd0, 16'h0000, 2'd0, 8'h00);
        nextCycle();
        reset = 1'b1;

        // Single write from the load unit; ptr ends at 2.
        applyStimulus(3'b010, 3'd0, 3'd5, 3'd0, 16'h0, 16'hBEEF, 16'h0, 1'b0);
        #1;
        checkOutput("single_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        checkPort("single", 1'b1, 3'd5, 16'hBEEF, REQ_LOAD, 8'h20);

        // Only requester 1 valid with ptr=2: wraps around to 1, writes reg 6.
        applyStimulus(3'b010, 3'd0, 3'd6, 3'd0, 16'h0, 16'h6666, 16'h0, 1'b0);
        #1;
        checkOutput("wrap_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        checkPort("wrap", 1'b1, 3'd6, 16'h6666, 2'd1, 8'h40);

        // Asynchronous reset mid-operation clears outputs before any edge.
        applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        reset = 1'b0;
        #1;
        checkPort("async_reset", 1'b0, 3'd0, 16'h0000, 2'd0, 8'h00);
        reset = 1'b1;
        #1;

        // Rotation from ptr=0, continued into the stall scenario:
        // grants 0,1,2,0,1,2,0 on consecutive cycles.
        rot_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        applyStimulus(3'b111, 3'd1, 3'd2, 3'd3,
                      ROT_DATA[0], ROT_DATA[1], ROT_DATA[2], 1'b0);
        for (int i = 0; i < 7; i++) begin
            #1;
            checkOutput($sformatf("rot%0d_ready", i), 32'(bus.req_ready),
                        32'(3'b001 << rot_seq[i]));
            nextCycle();
            checkPort($sformatf("rot%0d", i), 1'b1, 3'(rot_seq[i] + 2'd1),
                      ROT_DATA[rot_seq[i]], rot_seq[i],
                      8'(8'h01 << (rot_seq[i] + 2'd1)));
        end

        // Stall for two cycles after granting 0: nothing granted, ptr frozen.
        for (int i = 0; i < 2; i++) begin
            bus.wb_stall = 1'b1;
            #1;
            checkOutput($sformatf("stall%0d_ready", i), 32'(bus.req_ready), 32'h0);
            nextCycle();
            checkOutput($sformatf("stall%0d_we", i), 32'(bus.wb_we), 32'h0);
            checkOutput($sformatf("stall%0d_busy", i), 32'(bus.busy), 32'h0);
        end
        bus.wb_stall = 1'b0;
        #1;
        checkOutput("unstall_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        checkPort("unstall", 1'b1, 3'd2, ROT_DATA[1], 2'd1, 8'h04);

        // Move ptr to 0 with a lone immediate-move write.
        applyStimulus(3'b100, 3'd0, 3'd0, 3'd7, 16'h0, 16'h0, 16'h7777, 1'b0);
        #1;
        checkOutput("imm_ready", 32'(bus.req_ready), 32'h4);
        nextCycle();
        checkPort("imm", 1'b1, 3'd7, 16'h7777, REQ_IMM, 8'h80);

        // Same destination: 3/1111 then 3/2222 on consecutive cycles.
        applyStimulus(3'b101, 3'd3, 3'd0, 3'd3, 16'h1111, 16'h0, 16'h2222, 1'b0);
        #1;
        checkOutput("same0_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        checkPort("same0", 1'b1, 3'd3, 16'h1111, REQ_ALU, 8'h08);
        bus.req_valid = 3'b100;
        #1;
        checkOutput("same1_ready", 32'(bus.req_ready), 32'h4);
        nextCycle();
        checkPort("same1", 1'b1, 3'd3, 16'h2222, REQ_IMM, 8'h08);

        // Idle hold after writing 2/A5A5 (ptr moves from 0 to 1).
        applyStimulus(3'b001, 3'd2, 3'd0, 3'd0, 16'hA5A5, 16'h0, 16'h0, 1'b0);
        #1;
        checkOutput("idle_wr_ready", 32'(bus.req_ready), 32'h1);
        nextCycle();
        checkPort("idle_wr", 1'b1, 3'd2, 16'hA5A5, 2'd0, 8'h04);
        applyStimulus(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput($sformatf("idle%0d_ready", i), 32'(bus.req_ready), 32'h0);
            nextCycle();
            checkPort($sformatf("idle%0d", i), 1'b0, 3'd2, 16'hA5A5, 2'd0, 8'h00);
        end
        // ptr held at 1 through the idle cycles.
        applyStimulus(3'b111, 3'd1, 3'd4, 3'd3, 16'h0101, 16'h0404, 16'h0303, 1'b0);
        #1;
        checkOutput("idle_ptr_ready", 32'(bus.req_ready), 32'h2);
        nextCycle();
        checkPort("idle_ptr", 1'b1, 3'd4, 16'h0404, 2'd1, 8'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
